// File: rtl/ni_inject_sched.sv
// Injection scheduler for the router local port: holds one VC per wormhole packet,
// tracks per-VC downstream credits and round-robins sources onto a registered flit stream.
module ni_inject_sched #(
  parameter  int NUM_SRC    = 4,
  parameter  int NUM_VCS    = 2,
  parameter  int BUF_DEPTH  = 4,
  parameter  int DATA_W     = 32,
  localparam int VC_ID_BITS = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int CW         = $clog2(BUF_DEPTH + 1),
  localparam int SW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                              clk,
  input  logic                              arst_n,
  input  logic [NUM_SRC-1:0]                src_valid,
  input  logic [NUM_SRC-1:0]                src_head,
  input  logic [NUM_SRC-1:0]                src_tail,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]    src_data,
  output logic [NUM_SRC-1:0]                src_ready,
  output logic                              out_valid,
  output logic [VC_ID_BITS-1:0]             out_vc,
  output logic                              out_head,
  output logic                              out_tail,
  output logic [DATA_W-1:0]                 out_data,
  input  logic [NUM_VCS-1:0]                incredit,
  output logic [NUM_VCS-1:0][CW-1:0]        credits_avail,
  output logic                              err
);

  logic [NUM_VCS-1:0]                 vc_owned_q, vc_owned_d;
  logic [NUM_SRC-1:0]                 src_active_q, src_active_d;
  logic [NUM_SRC-1:0][VC_ID_BITS-1:0] src_vc_q, src_vc_d;
  logic [NUM_VCS-1:0][CW-1:0]         credits_q, credits_d;
  logic [SW-1:0]                      rr_ptr_q, rr_ptr_d;
  logic                               err_q, err_d;
  logic                               out_valid_q, out_head_q, out_tail_q;
  logic [VC_ID_BITS-1:0]              out_vc_q;
  logic [DATA_W-1:0]                  out_data_q;

  logic                               free_found_s;
  logic [VC_ID_BITS-1:0]              free_vc_s;
  logic [NUM_SRC-1:0]                 elig_s;
  logic [NUM_SRC-1:0][VC_ID_BITS-1:0] tgt_vc_s;
  logic                               proto_err_s;
  logic                               sat_err_s;
  logic                               gnt_found_s;
  logic [SW-1:0]                      gnt_idx_s;
  logic [SW-1:0]                      cand_s;
  logic [VC_ID_BITS-1:0]              gnt_vc_s;

  // Lowest-index FREE VC that still has credit (descending scan leaves the lowest).
  always_comb begin
    free_found_s = 1'b0;
    free_vc_s    = '0;
    for (int v = NUM_VCS - 1; v >= 0; v--) begin
      if (!vc_owned_q[v] && (credits_q[v] != '0)) begin
        free_found_s = 1'b1;
        free_vc_s    = VC_ID_BITS'(v);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  // Per-source eligibility; an IDLE source showing a non-head flit is a protocol error.
  always_comb begin
    proto_err_s = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      elig_s[s]   = 1'b0;
      tgt_vc_s[s] = free_vc_s;
      if (src_valid[s] && src_active_q[s]) begin
        tgt_vc_s[s] = src_vc_q[s];
        elig_s[s]   = (credits_q[src_vc_q[s]] != '0);
      end else if (src_valid[s] && src_head[s]) begin
        elig_s[s] = free_found_s;
      end else if (src_valid[s]) begin
        proto_err_s = 1'b1;
      end else begin
        elig_s[s] = 1'b0;
      end
    end
  end

  // Round-robin pick of one eligible source starting at rr_ptr.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand_s = SW'((int'(rr_ptr_q) + i) % NUM_SRC);
      if (!gnt_found_s && elig_s[cand_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
    gnt_vc_s  = tgt_vc_s[gnt_idx_s];
    src_ready = '0;
    if (gnt_found_s) begin
      src_ready[gnt_idx_s] = 1'b1;
    end else begin
      src_ready = '0;
    end
  end

  // Ownership and pointer update; a head+tail flit passes through the tail branch as a no-op.
  always_comb begin
    vc_owned_d   = vc_owned_q;
    src_active_d = src_active_q;
    src_vc_d     = src_vc_q;
    rr_ptr_d     = rr_ptr_q;
    if (gnt_found_s) begin
      rr_ptr_d = (gnt_idx_s == SW'(NUM_SRC - 1)) ? '0 : gnt_idx_s + SW'(1);
      if (src_tail[gnt_idx_s]) begin
        vc_owned_d[gnt_vc_s]    = 1'b0;
        src_active_d[gnt_idx_s] = 1'b0;
      end else if (src_head[gnt_idx_s] && !src_active_q[gnt_idx_s]) begin
        vc_owned_d[gnt_vc_s]    = 1'b1;
        src_active_d[gnt_idx_s] = 1'b1;
        src_vc_d[gnt_idx_s]     = gnt_vc_s;
      end else begin
        vc_owned_d = vc_owned_q;
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Credit counters: grant consumes, incredit returns, both together cancel.
  always_comb begin
    credits_d = credits_q;
    sat_err_s = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (incredit[v] && !(gnt_found_s && (gnt_vc_s == VC_ID_BITS'(v)))) begin
        if (credits_q[v] == CW'(BUF_DEPTH)) begin
          sat_err_s = 1'b1;
        end else begin
          credits_d[v] = credits_q[v] + CW'(1);
        end
      end else if (!incredit[v] && gnt_found_s && (gnt_vc_s == VC_ID_BITS'(v))) begin
        credits_d[v] = credits_q[v] - CW'(1);
      end else begin
        credits_d[v] = credits_q[v];
      end
    end
    err_d = err_q | proto_err_s | sat_err_s;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vc_owned_q   <= '0;
      src_active_q <= '0;
      src_vc_q     <= '0;
      credits_q    <= {NUM_VCS{CW'(BUF_DEPTH)}};
      rr_ptr_q     <= '0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_vc_q     <= '0;
      out_head_q   <= 1'b0;
      out_tail_q   <= 1'b0;
      out_data_q   <= '0;
    end else begin
      vc_owned_q   <= vc_owned_d;
      src_active_q <= src_active_d;
      src_vc_q     <= src_vc_d;
      credits_q    <= credits_d;
      rr_ptr_q     <= rr_ptr_d;
      err_q        <= err_d;
      out_valid_q  <= gnt_found_s;
      if (gnt_found_s) begin
        out_vc_q   <= gnt_vc_s;
        out_head_q <= src_head[gnt_idx_s];
        out_tail_q <= src_tail[gnt_idx_s];
        out_data_q <= src_data[gnt_idx_s];
      end else begin
        out_vc_q   <= out_vc_q;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_vc        = out_vc_q;
  assign out_head      = out_head_q;
  assign out_tail      = out_tail_q;
  assign out_data      = out_data_q;
  assign credits_avail = credits_q;
  assign err           = err_q;

endmodule
